// File: rtl/etm_pkg.sv
// Shared types for the ETM error monitor: run-control FSM states and drain length.
package etm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Matches the two register stages of etm_ed_unit.
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/etm_ed_unit.sv
// Two-stage error-distance datapath: S1 registers exact product and approx, S2 registers |exact-approx|.
// Latency 2 cycles, one sample per cycle, no back-pressure (free-running pipeline).
module etm_ed_unit #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] approx,
  output logic           ed_valid,
  output logic [2*W-1:0] ed
);

  logic           s1_valid;
  logic [2*W-1:0] s1_exact;
  logic [2*W-1:0] s1_approx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= '0;
    end else begin
      s1_valid <= valid;
      if (valid) begin
        s1_exact  <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        s1_approx <= approx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_valid <= 1'b0;
      ed       <= '0;
    end else begin
      ed_valid <= s1_valid;
      if (s1_valid) begin
        ed <= (s1_exact >= s1_approx) ? (s1_exact - s1_approx) : (s1_approx - s1_exact);
      end
    end
  end

endmodule

// File: rtl/etm_error_monitor.sv
// Accumulates error count, max and saturating sum of ED over a run of N ETM samples.
// Metrics land 2 cycles after acceptance; in_ready is high only in RUN, no downstream back-pressure.
module etm_error_monitor
  import etm_pkg::*;
#(
  parameter int W       = 24,
  parameter int NSAMP_W = 16,
  parameter int ACC_W   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSAMP_W-1:0] num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic [2*W-1:0]     approx_res,
  output logic               busy,
  output logic               done,
  output logic [NSAMP_W-1:0] err_count,
  output logic [2*W-1:0]     max_ed,
  output logic [ACC_W-1:0]   sum_ed,
  output logic               sum_sat
);

  state_t             state, state_n;
  logic [NSAMP_W-1:0] n_q;
  logic [NSAMP_W-1:0] cnt;
  logic [1:0]         drain_cnt;
  logic               accept;
  logic               start_ok;
  logic               ed_valid;
  logic [2*W-1:0]     ed;
  logic [ACC_W:0]     sum_wide;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign sum_wide = {1'b0, sum_ed} + {{(ACC_W + 1 - 2*W){1'b0}}, ed};

  etm_ed_unit #(.W(W)) u_ed (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (accept),
    .a        (op_a),
    .b        (op_b),
    .approx   (approx_res),
    .ed_valid (ed_valid),
    .ed       (ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = (num_samples == '0) ? DONE : RUN;
      RUN:        if (accept && (cnt == n_q - NSAMP_W'(1))) state_n = DRAIN;
      DRAIN:      if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  // The pipeline is empty whenever start is accepted, so clearing never races an ED update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
      sum_sat   <= 1'b0;
    end else if (start_ok) begin
      n_q       <= num_samples;
      cnt       <= '0;
      drain_cnt <= '0;
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
      sum_sat   <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + NSAMP_W'(1);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'(1) : 2'(0);
      if (ed_valid) begin
        err_count <= err_count + {{(NSAMP_W-1){1'b0}}, (ed != '0)};
        if (ed > max_ed) max_ed <= ed;
        if (sum_wide[ACC_W]) begin
          sum_ed  <= '1;
          sum_sat <= 1'b1;
        end else begin
          sum_ed <= sum_wide[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_etm_error_monitor.sv
// Randomized and directed bench for etm_error_monitor (W=8, ACC_W=16) against a run-level model.
module tb_etm_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_samples = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic [15:0] approx_res = '0;
  logic        busy;
  logic        done;
  logic [7:0]  err_count;
  logic [15:0] max_ed;
  logic [15:0] sum_ed;
  logic        sum_sat;

  etm_error_monitor #(.W(8), .NSAMP_W(8), .ACC_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .approx_res  (approx_res),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .max_ed      (max_ed),
    .sum_ed      (sum_ed),
    .sum_sat     (sum_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: which run is active, when it ends, and the EDs accepted so far.
  int m_cyc = 0;
  bit m_running = 0;
  bit m_ended = 0;
  int m_end = 0;
  int m_left = 0;
  int eds[$];
  bit chk_en = 0;

  function automatic int ed_of(input bit [7:0] a, input bit [7:0] b, input bit [15:0] x);
    int exact;
    exact = int'(a) * int'(b);
    return (exact > int'(x)) ? exact - int'(x) : int'(x) - exact;
  endfunction

  task automatic model_reset();
    m_running = 0;
    m_ended   = 0;
    eds.delete();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int e_cnt, e_max;
      longint e_sum;
      bit e_done;
      e_done = m_ended && (m_cyc >= m_end);
      check("in_ready", in_ready, m_running);
      check("busy", busy, m_running || (m_ended && m_cyc < m_end));
      check("done", done, e_done);
      if (e_done) begin
        e_cnt = 0; e_max = 0; e_sum = 0;
        foreach (eds[i]) begin
          if (eds[i] != 0) e_cnt++;
          if (eds[i] > e_max) e_max = eds[i];
          e_sum += eds[i];
        end
        check("err_count", err_count, e_cnt);
        check("max_ed", max_ed, e_max);
        check("sum_ed", sum_ed, (e_sum > 65535) ? 65535 : e_sum);
        check("sum_sat", sum_sat, e_sum > 65535);
      end
    end
  end

  // Drive one cycle of inputs starting just after a rising edge, and advance the model.
  task automatic step(input bit s, input bit [7:0] n, input bit v,
                      input bit [7:0] a, input bit [7:0] b, input bit [15:0] x);
    bit acc, st;
    start = s; num_samples = n; in_valid = v;
    op_a = a; op_b = b; approx_res = x;
    acc = m_running && v;
    st  = s && !m_running && !(m_ended && m_cyc < m_end);
    @(posedge clk);
    m_cyc++;
    if (st) begin
      eds.delete();
      m_ended = 0;
      if (n == 0) begin
        m_ended = 1;
        m_end   = m_cyc;
      end else begin
        m_running = 1;
        m_left    = n;
      end
    end
    if (acc) begin
      eds.push_back(ed_of(a, b, x));
      m_left--;
      if (m_left == 0) begin
        m_running = 0;
        m_ended   = 1;
        m_end     = m_cyc + 2;
      end
    end
    #1;
  endtask

  task automatic idle_step(input bit noisy);
    bit s;
    s = noisy && ($urandom_range(3) == 0);
    step(s, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    #1;
    model_reset();
    check("rst_outs", {in_ready, busy, done, err_count, max_ed, sum_ed, sum_sat}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit [7:0]  ta[16];
  bit [7:0]  tb[16];
  bit [15:0] tx[16];

  // Start a run of n samples from ta/tb/tx, with random gaps and junk starts; wait for done.
  task automatic run(input int n, input int gap_pct, input bit noisy);
    int i, guard, k;
    bit v;
    step(1'b1, 8'(n), 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
    if (n == 0) begin
      check("n0_done", done, 1);
      check("n0_ready", in_ready, 0);
      return;
    end
    i = 0; guard = 0;
    while (i < n && guard < 500) begin
      v = ($urandom_range(99) >= gap_pct) || (i == n - 1 && gap_pct == 0);
      step(noisy && ($urandom_range(7) == 0), 8'($urandom), v,
           v ? ta[i] : 8'($urandom), v ? tb[i] : 8'($urandom), v ? tx[i] : 16'($urandom));
      if (v) i++;
      guard++;
    end
    k = 0;
    while (done !== 1'b1 && k < 10) begin
      idle_step(noisy);
      k++;
    end
    check("done_latency", k, 2);
  endtask

  task automatic set_rand(input int n);
    for (int j = 0; j < n; j++) begin
      int exact, t;
      ta[j] = 8'($urandom); tb[j] = 8'($urandom);
      exact = int'(ta[j]) * int'(tb[j]);
      case ($urandom_range(2))
        0: tx[j] = 16'(exact);
        1: begin
          t = exact + int'($urandom_range(20)) - 10;
          if (t < 0) t = 0;
          tx[j] = 16'(t);
        end
        default: tx[j] = 16'($urandom);
      endcase
    end
  endtask

  initial begin
    #1;
    check("init_outs", {in_ready, busy, done, err_count, max_ed, sum_ed, sum_sat}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    ta[0] = 8'h12; tb[0] = 8'h34; tx[0] = 16'h037F;
    run(1, 0, 0);
    check("t1_cnt", err_count, 1);
    check("t1_max", max_ed, 16'h29);
    check("t1_sum", sum_ed, 16'h29);

    ta[0] = 8'h05; tb[0] = 8'h07; tx[0] = 16'h0023;
    run(1, 0, 0);
    check("t2_cnt", err_count, 0);
    check("t2_sum", sum_ed, 0);
    check("t2_max", max_ed, 0);

    ta[0] = 8'd3; tb[0] = 8'd3; tx[0] = 16'd6;
    ta[1] = 8'd4; tb[1] = 8'd5; tx[1] = 16'd30;
    ta[2] = 8'd7; tb[2] = 8'd7; tx[2] = 16'd49;
    ta[3] = 8'd2; tb[3] = 8'd8; tx[3] = 16'd9;
    run(4, 0, 0);
    check("t3_cnt", err_count, 3);
    check("t3_sum", sum_ed, 20);
    check("t3_max", max_ed, 10);

    for (int j = 0; j < 2; j++) begin
      ta[j] = 8'hFF; tb[j] = 8'hFF; tx[j] = 16'h0000;
    end
    run(2, 0, 0);
    check("t4_sum", sum_ed, 16'hFFFF);
    check("t4_sat", sum_sat, 1);
    check("t4_max", max_ed, 16'hFE01);

    run(0, 0, 0);
    check("t5_cnt", err_count, 0);
    check("t5_sum", sum_ed, 0);
    check("t5_sat", sum_sat, 0);
    idle_step(0);
    check("t5_hold", done, 1);

    set_rand(10);
    step(1'b1, 8'd10, 1'b0, 8'h0, 8'h0, 16'h0);
    for (int j = 0; j < 3; j++) step(1'b1, 8'd1, 1'b1, ta[j], tb[j], tx[j]);
    do_reset();
    for (int j = 0; j < 2; j++) begin
      ta[j] = 8'hFF; tb[j] = 8'hFF; tx[j] = 16'h0001;
    end
    step(1'b1, 8'd2, 1'b0, 8'h0, 8'h0, 16'h0);
    step(1'b0, 8'd0, 1'b1, ta[0], tb[0], tx[0]);
    step(1'b0, 8'd0, 1'b1, ta[1], tb[1], tx[1]);
    idle_step(0);
    check("t6_in_drain", busy, 1);
    do_reset();
    ta[0] = 8'h12; tb[0] = 8'h34; tx[0] = 16'h037F;
    run(1, 0, 0);
    check("t6_cnt", err_count, 1);
    check("t6_sum", sum_ed, 16'h29);
    check("t6_sat", sum_sat, 0);

    for (int r = 0; r < 40; r++) begin
      int n;
      n = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 12));
      set_rand(n);
      run(n, int'($urandom_range(0, 50)), 1);
      if ($urandom_range(5) == 0) idle_step(0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
